// File: rtl/batch_cycle_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// BatchCtrl: definitions shared by the batch sequencer, its delay line and
// the testbench.
//   NUM_BANKS  - number of memory banks rotated through the four roles
//   bankSel_t  - bank index type (write / lookahead / calc / idle)
//   dsd()      - down-sampled batch depth, ceil(depth / OSR)
//   cw()       - address width for a batch of the given depth, minimum 1
// ---------------------------------------------------------------------------
package BatchCtrl;

    localparam int NUM_BANKS = 4;

    typedef logic [1:0] bankSel_t;

    function automatic int dsd(input int depth, input int osr);
        return (depth + osr - 1) / osr;
    endfunction

    // $clog2(1) is 0, but a one-entry batch still needs a one-bit address.
    function automatic int cw(input int batch_depth);
        return (batch_depth <= 1) ? 1 : $clog2(batch_depth);
    endfunction

endpackage

// File: rtl/batch_cycle_ctrl_delay_line.sv
// ---------------------------------------------------------------------------
// batch_delay_line: generic shift register with synchronous reset. It shifts
// on every clock, with no enable, so idle cycles travel down the line as
// bubbles.
//   clk   in            clock
//   rst   in            synchronous, active-high reset; loads RST_VAL
//   din   in  W         word entering stage 0
//   taps  out STAGES*W  taps[k] is din delayed by k+1 clocks
// ---------------------------------------------------------------------------
module batch_delay_line #(
    parameter int             W       = 8,
    parameter int             STAGES  = 3,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [W-1:0]                 din,
    output logic [STAGES-1:0][W-1:0]     taps
);

    // NOTE: the stages are ordinary flops with a known reset value, not a
    // memory, so every stage is reset and downstream logic never sees X.
    always_ff @(posedge clk) begin
        if (rst) begin
            taps <= {STAGES{RST_VAL}};
        end else begin
            taps[0] <= din;
            for (int k = 1; k < STAGES; k++) begin
                taps[k] <= taps[k-1];
            end
        end
    end

endmodule

// File: rtl/batch_cycle_ctrl.sv
// ---------------------------------------------------------------------------
// batch_cycle_ctrl: sequencer for the batch-based control-bounded filter.
// It counts accepted down-sampled samples into batches of DSD, rotates four
// banks through the write / lookahead / calc / idle roles, and delays the
// addresses and bank index by three clocks for the result-combining stages.
//   clk               in       down-sampled clock
//   rst               in       synchronous, active-high reset
//   in_valid          in       one input word accepted this clock
//   batCount          out CW   forward address in the batch, 0..DSD-1
//   batCountRev       out CW   reverse address, DSD-1-batCount
//   cyclePulse        out      one clock high after a batch completes
//   cycle             out 2    bank being written
//   cycleLH           out 2    lookahead bank (cycle-1)
//   cycleCalc         out 2    calc bank (cycle-2)
//   cycleIdle         out 2    idle bank, next to be written (cycle-3)
//   delayBatCount     out 3xCW batCount delayed k+1 clocks at index k
//   delayBatCountRev  out 3xCW batCountRev delayed k+1 clocks
//   delayCycle        out 3x2  cycle delayed k+1 clocks
//   out_valid         out      valid bit of the delay-3 stage
// ---------------------------------------------------------------------------
module batch_cycle_ctrl
    import BatchCtrl::*;
#(
    parameter  int depth = 32,
    parameter  int OSR   = 1,
    localparam int DSD   = dsd(depth, OSR),
    localparam int CW    = cw(DSD)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic [CW-1:0]        batCount,
    output logic [CW-1:0]        batCountRev,
    output logic                 cyclePulse,
    output bankSel_t             cycle,
    output bankSel_t             cycleLH,
    output bankSel_t             cycleCalc,
    output bankSel_t             cycleIdle,
    output logic [2:0][CW-1:0]   delayBatCount,
    output logic [2:0][CW-1:0]   delayBatCountRev,
    output bankSel_t [2:0]       delayCycle,
    output logic                 out_valid
);

    localparam logic [CW-1:0] LAST   = CW'(DSD - 1);
    localparam int            STAGES = 3;
    // Packed stage word: {batCount, batCountRev, cycle, valid}.
    localparam int            W      = 2 * CW + 3;

    logic       wrap;
    logic [1:0] batches_done;
    logic       warm;

    // Wrap compares against DSD-1, not the all-ones address, so batches
    // whose depth is not a power of two still close on time.
    assign wrap = in_valid && (batCount == LAST);
    assign warm = (batches_done == 2'd3);

    // NOTE: every register below is assigned with <=, so all of them sample
    // the pre-edge values and the update order inside the block is irrelevant.
    always_ff @(posedge clk) begin
        if (rst) begin
            batCount     <= '0;
            cycle        <= '0;
            cyclePulse   <= 1'b0;
            batches_done <= 2'd0;
        end else begin
            cyclePulse <= wrap;
            if (in_valid) begin
                batCount <= wrap ? '0 : batCount + 1'b1;
            end
            if (wrap) begin
                cycle <= cycle + 2'd1;
                // Saturates: fill, lookahead and calc batches are all that
                // is needed before results become meaningful.
                if (!warm) begin
                    batches_done <= batches_done + 2'd1;
                end
            end
        end
    end

    assign batCountRev = LAST - batCount;

    // Bank roles trail the write bank; 2-bit wraparound gives mod 4.
    assign cycleLH   = cycle - 2'd1;
    assign cycleCalc = cycle - 2'd2;
    assign cycleIdle = cycle - 2'd3;

    logic [W-1:0]             stage_in;
    logic [STAGES-1:0][W-1:0] taps;

    assign stage_in = {batCount, batCountRev, cycle, in_valid && warm};

    batch_delay_line #(
        .W       (W),
        .STAGES  (STAGES),
        .RST_VAL ({{CW{1'b0}}, LAST, 2'b00, 1'b0})
    ) u_delay (
        .clk  (clk),
        .rst  (rst),
        .din  (stage_in),
        .taps (taps)
    );

    for (genvar k = 0; k < STAGES; k++) begin : g_unpack
        assign delayBatCount[k]    = taps[k][W-1 -: CW];
        assign delayBatCountRev[k] = taps[k][W-1-CW -: CW];
        assign delayCycle[k]       = taps[k][2:1];
    end

    assign out_valid = taps[STAGES-1][0];

endmodule

// File: tb/tb_batch_cycle_ctrl.sv
// ---------------------------------------------------------------------------
// tb_batch_cycle_ctrl: three sequencer instances (DSD 32, 7 and 1) share one
// clock, reset and in_valid. A reference model tracks only the number of
// samples accepted since reset per instance and derives address, bank,
// pulse and warm-up from it arithmetically; a three-entry history per
// instance provides the expected delay-line taps.
// ---------------------------------------------------------------------------
module tb_batch_cycle_ctrl;
    import BatchCtrl::*;

    localparam int NDUT    = 3;
    localparam int NFIELDS = 17;

    function automatic int depth_of(input int g);
        return (g == 0) ? 32 : (g == 1) ? 20 : 1;
    endfunction

    function automatic int osr_of(input int g);
        return (g == 1) ? 3 : 1;
    endfunction

    logic clk;
    logic rst;
    logic in_valid;

    // obs[dut][field]: every DUT output zero-extended to 32 bits.
    // Fields: 0 batCount, 1 batCountRev, 2 cyclePulse, 3 cycle, 4 cycleLH,
    // 5 cycleCalc, 6 cycleIdle, 7..9 delayBatCount, 10..12 delayBatCountRev,
    // 13..15 delayCycle, 16 out_valid.
    logic [31:0] obs [NDUT][NFIELDS];

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int D = dsd(depth_of(g), osr_of(g));
        localparam int C = cw(D);

        logic [C-1:0]       bc;
        logic [C-1:0]       rev;
        logic               pulse;
        bankSel_t           cyc;
        bankSel_t           lh;
        bankSel_t           calc;
        bankSel_t           idle;
        logic [2:0][C-1:0]  dbc;
        logic [2:0][C-1:0]  drev;
        bankSel_t [2:0]     dcyc;
        logic               ov;

        batch_cycle_ctrl #(
            .depth (depth_of(g)),
            .OSR   (osr_of(g))
        ) dut (
            .clk              (clk),
            .rst              (rst),
            .in_valid         (in_valid),
            .batCount         (bc),
            .batCountRev      (rev),
            .cyclePulse       (pulse),
            .cycle            (cyc),
            .cycleLH          (lh),
            .cycleCalc        (calc),
            .cycleIdle        (idle),
            .delayBatCount    (dbc),
            .delayBatCountRev (drev),
            .delayCycle       (dcyc),
            .out_valid        (ov)
        );

        assign obs[g][0]  = 32'(bc);
        assign obs[g][1]  = 32'(rev);
        assign obs[g][2]  = 32'(pulse);
        assign obs[g][3]  = 32'(cyc);
        assign obs[g][4]  = 32'(lh);
        assign obs[g][5]  = 32'(calc);
        assign obs[g][6]  = 32'(idle);
        for (genvar k = 0; k < 3; k++) begin : g_taps
            assign obs[g][7+k]  = 32'(dbc[k]);
            assign obs[g][10+k] = 32'(drev[k]);
            assign obs[g][13+k] = 32'(dcyc[k]);
        end
        assign obs[g][16] = 32'(ov);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int passes;

    // Reference model state.
    int dsdv   [NDUT];
    int n_acc  [NDUT];      // samples accepted since the last reset
    int pulse_m[NDUT];
    int h_bc   [NDUT][3];   // history of pre-edge values, [0] = newest
    int h_rev  [NDUT][3];
    int h_cyc  [NDUT][3];
    int h_val  [NDUT][3];

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        checks++;
        assert (observed === expected) passes++;
        else $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    endtask

    task automatic model_edge(input bit v, input bit r);
        for (int i = 0; i < NDUT; i++) begin
            int d;
            int cur_bc;
            d = dsdv[i];
            if (r) begin
                n_acc[i]   = 0;
                pulse_m[i] = 0;
                for (int k = 0; k < 3; k++) begin
                    h_bc[i][k]  = 0;
                    h_rev[i][k] = d - 1;
                    h_cyc[i][k] = 0;
                    h_val[i][k] = 0;
                end
            end else begin
                cur_bc     = n_acc[i] % d;
                pulse_m[i] = (v && cur_bc == d - 1) ? 1 : 0;
                for (int k = 2; k > 0; k--) begin
                    h_bc[i][k]  = h_bc[i][k-1];
                    h_rev[i][k] = h_rev[i][k-1];
                    h_cyc[i][k] = h_cyc[i][k-1];
                    h_val[i][k] = h_val[i][k-1];
                end
                h_bc[i][0]  = cur_bc;
                h_rev[i][0] = d - 1 - cur_bc;
                h_cyc[i][0] = (n_acc[i] / d) % NUM_BANKS;
                // Warm once three complete batches have been accepted.
                h_val[i][0] = (v && (n_acc[i] / d) >= 3) ? 1 : 0;
                if (v) n_acc[i]++;
            end
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < NDUT; i++) begin
            int d;
            int bc;
            int cy;
            string p;
            d  = dsdv[i];
            bc = n_acc[i] % d;
            cy = (n_acc[i] / d) % NUM_BANKS;
            p  = $sformatf("dsd%0d.", d);
            check({p, "batCount"},    obs[i][0], bc);
            check({p, "batCountRev"}, obs[i][1], d - 1 - bc);
            check({p, "cyclePulse"},  obs[i][2], pulse_m[i]);
            check({p, "cycle"},       obs[i][3], cy);
            check({p, "cycleLH"},     obs[i][4], (cy + 3) % NUM_BANKS);
            check({p, "cycleCalc"},   obs[i][5], (cy + 2) % NUM_BANKS);
            check({p, "cycleIdle"},   obs[i][6], (cy + 1) % NUM_BANKS);
            for (int k = 0; k < 3; k++) begin
                check($sformatf("%sdelayBatCount[%0d]", p, k),    obs[i][7+k],  h_bc[i][k]);
                check($sformatf("%sdelayBatCountRev[%0d]", p, k), obs[i][10+k], h_rev[i][k]);
                check($sformatf("%sdelayCycle[%0d]", p, k),       obs[i][13+k], h_cyc[i][k]);
            end
            check({p, "out_valid"}, obs[i][16], h_val[i][2]);
        end
    endtask

    // One clock: drive inputs, let the edge happen, advance the model and
    // compare 1 time unit after the edge.
    task automatic tick(input bit v, input bit r);
        in_valid = v;
        rst      = r;
        @(posedge clk);
        model_edge(v, r);
        #1;
        check_all();
    endtask

    initial begin
        checks   = 0;
        passes   = 0;
        rst      = 1'b1;
        in_valid = 1'b0;
        for (int i = 0; i < NDUT; i++) begin
            dsdv[i] = dsd(depth_of(i), osr_of(i));
        end

        // Reset, including reset winning over in_valid.
        tick(1'b0, 1'b1);
        tick(1'b1, 1'b1);

        // One full DSD=32 batch plus the return to address 0.
        for (int c = 0; c < 33; c++) tick(1'b1, 1'b0);

        // Alternating valid/idle: counters hold, bubbles propagate.
        for (int c = 0; c < 64; c++) tick(c[0] == 1'b0, 1'b0);

        // Continuous valid across several batches, through warm-up.
        tick(1'b0, 1'b1);
        for (int c = 0; c < 5 * 32 + 4; c++) tick(1'b1, 1'b0);

        // Random valid pattern.
        for (int c = 0; c < 200; c++) tick($urandom_range(0, 3) != 0, 1'b0);

        // Reset mid-batch at batCount=17, cycle=2 of the DSD=32 instance,
        // then warm-up must take three new full batches.
        tick(1'b0, 1'b1);
        for (int c = 0; c < 2 * 32 + 17; c++) tick(1'b1, 1'b0);
        tick($urandom_range(0, 1) != 0, 1'b1);
        for (int c = 0; c < 3 * 32 + 5; c++) tick(1'b1, 1'b0);

        // rst together with in_valid on the last address: no pulse, bank 0.
        tick(1'b0, 1'b1);
        for (int c = 0; c < 31; c++) tick(1'b1, 1'b0);
        tick(1'b1, 1'b1);
        tick(1'b1, 1'b0);

        // Random tail with occasional resets.
        for (int c = 0; c < 300; c++) begin
            tick($urandom_range(0, 4) != 0, $urandom_range(0, 63) == 0);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
